sha3_pad_packer: RTL and testbench

//  Input stage of the SHA3/SHAKE datapath, directly upstream of the Keccak core. Packs a
//  64-bit message word stream into one rate-sized block (up to 1344 bits) and applies

---
 rtl/sha3_pad_packer.sv | 225 ++++++++++++++++++++++
 tb/tb_sha3_pad_packer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha3_pad_packer.sv
// sha3_pad_packer: packs a 64-bit message word stream into one rate-sized block for
// the Keccak core and applies the SHA3/SHAKE multi-rate padding (domain suffix byte,
// then 0x80 in the last byte of the rate). Rate and suffix are chosen by mode_sel_i
// and captured on the first word of each message.
//
// Block layout: byte j of the block is blk_out[8j:8j+7] with blk_out[8j] as the byte
// MSB. Word slot s occupies bytes 8s..8s+7, so a word lands verbatim at
// blk_out[64s:64s+63]. Bytes at or above 8R are always zero.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_FILL  | accepting words into slot cnt; padding applied on the last word
//   S_EMIT  | block presented on blk_out, held until blk_ready
//   S_PADBLK| one cycle to build a pad-only block after a full final block

module sha3_pad_packer #(
    parameter int         W        = 64,
    parameter int         MAXR     = 21,
    parameter logic [7:0] SFX_SHA3 = 8'h06,
    parameter logic [7:0] SFX_SHK  = 8'h1F
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        mode_sel_i,
    input  logic [0:W-1]      din64,
    input  logic              din_valid,
    input  logic              din_last,
    input  logic [3:0]        din_bytes,
    output logic              din_ready,
    input  logic              blk_ready,
    output logic [0:W*MAXR-1] blk_out,
    output logic              blk_valid,
    output logic              blk_last
);

    localparam int NBYTES = (W * MAXR) / 8;

    typedef enum logic [1:0] {
        S_FILL   = 2'd0,
        S_EMIT   = 2'd1,
        S_PADBLK = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [0:W*MAXR-1]   buf_q, buf_d;
    logic                pad_pend_q, pad_pend_d;
    logic                last_q, last_d;
    logic                open_q, open_d;
    logic [4:0]          rate_q, rate_d;
    logic [7:0]          sfx_q, sfx_d;

    logic [4:0]          cur_rate;
    logic [4:0]          rate_m1;
    logic [7:0]          cur_sfx;
    logic [7:0]          last_byte_idx;
    logic [3:0]          nb;
    logic                word_full;
    logic                at_end;
    logic                accept;
    logic [7:0]          byte_v;

    function automatic logic [4:0] rate_of(input logic [2:0] m);
        logic [4:0] r;
        case (m)
            3'd0:    r = 5'd21;
            3'd1:    r = 5'd17;
            3'd2:    r = 5'd9;
            3'd3:    r = 5'd13;
            3'd5:    r = 5'd18;
            default: r = 5'd17;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] sfx_of(input logic [2:0] m);
        return (m == 3'd0 || m == 3'd1) ? SFX_SHK : SFX_SHA3;
    endfunction

    // Mode in effect: live input until a message opens, latched value afterwards
    always_comb begin
        cur_rate      = open_q ? rate_q : rate_of(mode_sel_i);
        cur_sfx       = open_q ? sfx_q  : sfx_of(mode_sel_i);
        rate_m1       = cur_rate - 5'd1;
        last_byte_idx = {rate_m1, 3'b111};
        nb            = (din_bytes > 4'd8) ? 4'd8 : din_bytes;
        word_full     = (nb == 4'd8);
        at_end        = (cnt_q == rate_m1);
        accept        = din_valid && (state_q == S_FILL);
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pad_pend_d = pad_pend_q;
        last_d     = last_q;
        open_d     = open_q;
        rate_d     = rate_q;
        sfx_d      = sfx_q;
        din_ready  = (state_q == S_FILL);
        blk_valid  = (state_q == S_EMIT);
        case (state_q)
            S_FILL: begin
                if (accept) begin
                    if (!open_q) begin
                        open_d = 1'b1;
                        rate_d = rate_of(mode_sel_i);
                        sfx_d  = sfx_of(mode_sel_i);
                    end
                    if (!din_last) begin
                        if (at_end) begin
                            state_d = S_EMIT;
                            last_d  = 1'b0;
                        end else begin
                            cnt_d = cnt_q + 5'd1;
                        end
                    end else if (word_full && at_end) begin
                        // Full final block: padding needs a block of its own
                        state_d    = S_EMIT;
                        last_d     = 1'b0;
                        pad_pend_d = 1'b1;
                    end else begin
                        state_d = S_EMIT;
                        last_d  = 1'b1;
                    end
                end
            end
            S_EMIT: begin
                if (blk_ready) begin
                    cnt_d   = 5'd0;
                    last_d  = 1'b0;
                    state_d = pad_pend_q ? S_PADBLK : S_FILL;
                    if (last_q) begin
                        open_d = 1'b0;
                    end
                end
            end
            S_PADBLK: begin
                pad_pend_d = 1'b0;
                last_d     = 1'b1;
                state_d    = S_EMIT;
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    // Block buffer update: word write with in-place padding, clear on handshake
    always_comb begin
        buf_d  = buf_q;
        byte_v = 8'h00;
        case (state_q)
            S_FILL: begin
                if (accept) begin
                    for (int j = 0; j < NBYTES; j++) begin
                        byte_v = buf_q[8*j +: 8];
                        if (5'(j / 8) == cnt_q) begin
                            byte_v = din64[8*(j % 8) +: 8];
                            if (din_last && (4'(j % 8) >= nb)) begin
                                byte_v = (4'(j % 8) == nb) ? cur_sfx : 8'h00;
                            end
                        end
                        if (din_last && word_full && !at_end &&
                            (5'(j / 8) == cnt_q + 5'd1) && ((j % 8) == 0)) begin
                            byte_v = cur_sfx;
                        end
                        if (din_last && !(word_full && at_end) && (8'(j) == last_byte_idx)) begin
                            byte_v = byte_v | 8'h80;
                        end
                        buf_d[8*j +: 8] = byte_v;
                    end
                end
            end
            S_EMIT: begin
                if (blk_ready) begin
                    buf_d = '0;
                end
            end
            S_PADBLK: begin
                for (int j = 0; j < NBYTES; j++) begin
                    byte_v = buf_q[8*j +: 8];
                    if (j == 0) begin
                        byte_v = cur_sfx;
                    end
                    if (8'(j) == last_byte_idx) begin
                        byte_v = byte_v | 8'h80;
                    end
                    buf_d[8*j +: 8] = byte_v;
                end
            end
            default: begin
                buf_d = buf_q;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_FILL;
            cnt_q      <= 5'd0;
            buf_q      <= '0;
            pad_pend_q <= 1'b0;
            last_q     <= 1'b0;
            open_q     <= 1'b0;
            rate_q     <= 5'd17;
            sfx_q      <= SFX_SHA3;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            pad_pend_q <= pad_pend_d;
            last_q     <= last_d;
            open_q     <= open_d;
            rate_q     <= rate_d;
            sfx_q      <= sfx_d;
        end
    end

    assign blk_out  = buf_q;
    assign blk_last = last_q;

endmodule

// File: tb/tb_sha3_pad_packer.sv
// Testbench for sha3_pad_packer: scoreboard of expected blocks built from a
// byte-level pad10*1 model, compared at each block handshake.

module tb_sha3_pad_packer;

    logic            clk = 1'b0;
    logic            reset;
    logic [2:0]      mode_sel_i;
    logic [0:63]     din64;
    logic            din_valid;
    logic            din_last;
    logic [3:0]      din_bytes;
    logic            din_ready;
    logic            blk_ready;
    logic [0:1343]   blk_out;
    logic            blk_valid;
    logic            blk_last;

    typedef struct {
        logic [0:1343] data;
        logic          last;
    } blk_t;

    blk_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;
    logic [7:0]    msg_b [0:1023];
    logic [0:1343] obs_data;
    logic          obs_last;
    int            obs_count = 0;

    sha3_pad_packer dut (
        .clk        (clk),
        .reset      (reset),
        .mode_sel_i (mode_sel_i),
        .din64      (din64),
        .din_valid  (din_valid),
        .din_last   (din_last),
        .din_bytes  (din_bytes),
        .din_ready  (din_ready),
        .blk_ready  (blk_ready),
        .blk_out    (blk_out),
        .blk_valid  (blk_valid),
        .blk_last   (blk_last)
    );

    always #5 clk = ~clk;

    function automatic int rate_words(input logic [2:0] m);
        case (m)
            3'd0:    return 21;
            3'd1:    return 17;
            3'd2:    return 9;
            3'd3:    return 13;
            3'd5:    return 18;
            default: return 17;
        endcase
    endfunction

    function automatic logic [7:0] sfx_byte(input logic [2:0] m);
        return (m <= 3'd1) ? 8'h1F : 8'h06;
    endfunction

    // Expected blocks: message || suffix || 0.. padded to the rate, 0x80 ORed into the final byte
    task automatic push_expected(input logic [2:0] m, input int len);
        int         rb;
        int         total;
        logic [7:0] p [0:2047];
        blk_t       b;
        rb    = 8 * rate_words(m);
        total = ((len + 1 + rb - 1) / rb) * rb;
        for (int i = 0; i < total; i++) begin
            if (i < len)       p[i] = msg_b[i];
            else if (i == len) p[i] = sfx_byte(m);
            else               p[i] = 8'h00;
        end
        p[total-1] = p[total-1] | 8'h80;
        for (int k = 0; k < total / rb; k++) begin
            b.data = '0;
            for (int j = 0; j < rb; j++) b.data[8*j +: 8] = p[k*rb + j];
            b.last = (k == total / rb - 1);
            exp_q.push_back(b);
        end
    endtask

    // Block monitor: compare every handshake against the scoreboard head
    initial begin : monitor
        blk_t mb;
        int   bad;
        forever begin
            @(negedge clk);
            #1;
            if (!reset && blk_valid && blk_ready) begin
                obs_data  = blk_out;
                obs_last  = blk_last;
                obs_count = obs_count + 1;
                checks    = checks + 1;
                if (exp_q.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL unexpected_block: got a block (blk_last=%0b), required none", blk_last);
                end else begin
                    mb  = exp_q.pop_front();
                    bad = -1;
                    for (int k = 167; k >= 0; k--) begin
                        if (blk_out[8*k +: 8] !== mb.data[8*k +: 8]) bad = k;
                    end
                    if (bad >= 0) begin
                        errors = errors + 1;
                        $display("FAIL blk_data: first differing byte %0d got %h, required %h",
                                 bad, blk_out[8*bad +: 8], mb.data[8*bad +: 8]);
                    end
                    checks = checks + 1;
                    if (blk_last !== mb.last) begin
                        errors = errors + 1;
                        $display("FAIL blk_last: got %0b, required %0b", blk_last, mb.last);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_word(input logic [0:63] w, input logic last, input logic [3:0] nb,
                              input logic [2:0] m);
        int n;
        n = 0;
        @(negedge clk);
        din64      = w;
        din_last   = last;
        din_bytes  = nb;
        mode_sel_i = m;
        din_valid  = 1'b1;
        while (din_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks = checks + 1;
        if (n >= 2000) begin
            errors = errors + 1;
            $display("FAIL word_accept: din_ready got %b after %0d cycles, required 1", din_ready, n);
        end
    endtask

    task automatic idle_inputs();
        @(negedge clk);
        din_valid = 1'b0;
        din_last  = 1'b0;
    endtask

    task automatic fill_msg(input int len);
        for (int i = 0; i < len; i++) msg_b[i] = 8'($urandom_range(0, 255));
    endtask

    // Drive one message of msg_b[0:len-1]; bytes past len in the last word are junk
    task automatic send_msg(input logic [2:0] m, input int len, input bit illegal_nb);
        int          nwords;
        logic [0:63] w;
        logic [3:0]  nb;
        logic        lw;
        nwords = (len == 0) ? 1 : (len + 7) / 8;
        push_expected(m, len);
        for (int wi = 0; wi < nwords; wi++) begin
            w = {$urandom, $urandom};
            for (int k = 0; k < 8; k++) begin
                if (8*wi + k < len) w[8*k +: 8] = msg_b[8*wi + k];
            end
            lw = (wi == nwords - 1);
            nb = lw ? 4'(len - 8*wi) : 4'd8;
            if (illegal_nb && lw && nb == 4'd8) nb = 4'($urandom_range(9, 15));
            drive_word(w, lw, nb, (wi == 0) ? m : 3'($urandom_range(0, 7)));
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL %s_drain: %0d blocks outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
        #2;
        checks = checks + 1;
        if (din_ready !== 1'b1 || blk_valid !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL %s_idle: din_ready=%b blk_valid=%b, required 1 0", name, din_ready, blk_valid);
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        din_valid  = 1'b0;
        din_last   = 1'b0;
        din_bytes  = 4'd0;
        din64      = '0;
        mode_sel_i = 3'd4;
        blk_ready  = 1'b1;
        #3;
        checks = checks + 1;
        if (din_ready !== 1'b1 || blk_valid !== 1'b0 || blk_last !== 1'b0 || blk_out !== '0) begin
            errors = errors + 1;
            $display("FAIL reset_state: din_ready=%b blk_valid=%b blk_last=%b blk_out_zero=%b, required 1 0 0 1",
                     din_ready, blk_valid, blk_last, (blk_out == '0));
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_empty_msg();
        logic [0:1343] e;
        int            c0;
        c0 = obs_count;
        send_msg(3'd4, 0, 1'b0);
        idle_inputs();
        wait_drain("empty");
        e = '0;
        e[0:7] = 8'h06;
        e[8*135 +: 8] = 8'h80;
        checks = checks + 1;
        if (obs_count - c0 !== 1 || obs_data !== e || obs_last !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL empty_block: blocks=%0d byte0=%h byte135=%h last=%b, required 1 06 80 1",
                     obs_count - c0, obs_data[0:7], obs_data[8*135 +: 8], obs_last);
        end
    endtask

    task automatic test_full_then_pad();
        logic [0:1343] e;
        int            c0;
        c0 = obs_count;
        fill_msg(136);
        send_msg(3'd4, 136, 1'b0);
        idle_inputs();
        wait_drain("padblk");
        e = '0;
        e[0:7] = 8'h06;
        e[8*135 +: 8] = 8'h80;
        checks = checks + 1;
        if (obs_count - c0 !== 2 || obs_data !== e || obs_last !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL pad_only_block: blocks=%0d byte0=%h byte135=%h last=%b, required 2 06 80 1",
                     obs_count - c0, obs_data[0:7], obs_data[8*135 +: 8], obs_last);
        end
    endtask

    task automatic test_coincide();
        int c0;
        c0 = obs_count;
        fill_msg(71);
        send_msg(3'd2, 71, 1'b0);
        idle_inputs();
        wait_drain("coincide");
        checks = checks + 1;
        if (obs_count - c0 !== 1 || obs_data[8*71 +: 8] !== 8'h86 || obs_last !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL coincide_byte: blocks=%0d byte71=%h last=%b, required 1 86 1",
                     obs_count - c0, obs_data[8*71 +: 8], obs_last);
        end
    endtask

    task automatic test_shake128();
        fill_msg(19);
        send_msg(3'd0, 19, 1'b0);
        idle_inputs();
        wait_drain("shake128");
        checks = checks + 1;
        if (obs_data[8*19 +: 8] !== 8'h1F || obs_data[8*167 +: 8] !== 8'h80 ||
            obs_data[8*24 +: 8*143] !== '0) begin
            errors = errors + 1;
            $display("FAIL shake128_pad: byte19=%h byte167=%h words3to20_zero=%b, required 1f 80 1",
                     obs_data[8*19 +: 8], obs_data[8*167 +: 8], (obs_data[8*24 +: 8*143] == '0));
        end
    endtask

    task automatic test_backpressure();
        logic [0:1343] held;
        int            n;
        @(negedge clk);
        blk_ready = 1'b0;
        fill_msg(20);
        send_msg(3'd3, 20, 1'b0);
        idle_inputs();
        n = 0;
        while (blk_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        #2;
        held = blk_out;
        fill_msg(10);
        fork
            send_msg(3'd5, 10, 1'b0);
            begin
                repeat (10) begin
                    @(negedge clk);
                    #2;
                    checks = checks + 1;
                    if (blk_valid !== 1'b1 || din_ready !== 1'b0 || blk_out !== held) begin
                        errors = errors + 1;
                        $display("FAIL hold_stable: blk_valid=%b din_ready=%b blk_out_same=%b, required 1 0 1",
                                 blk_valid, din_ready, (blk_out == held));
                    end
                end
                @(negedge clk);
                blk_ready = 1'b1;
            end
        join
        idle_inputs();
        wait_drain("backpressure");
    endtask

    task automatic test_reset_mid_fill();
        for (int i = 0; i < 5; i++) drive_word({$urandom, $urandom}, 1'b0, 4'd8, 3'd5);
        idle_inputs();
        #2;
        reset = 1'b1;
        #1;
        checks = checks + 1;
        if (din_ready !== 1'b1 || blk_valid !== 1'b0 || blk_last !== 1'b0 || blk_out !== '0) begin
            errors = errors + 1;
            $display("FAIL reset_mid_fill: din_ready=%b blk_valid=%b blk_last=%b blk_out_zero=%b, required 1 0 0 1",
                     din_ready, blk_valid, blk_last, (blk_out == '0));
        end
        @(negedge clk);
        reset = 1'b0;
        fill_msg(149);
        send_msg(3'd5, 149, 1'b0);
        idle_inputs();
        wait_drain("sha3_224");
    endtask

    task automatic test_boundaries();
        int rb;
        for (int m = 0; m < 6; m++) begin
            rb = 8 * rate_words(3'(m));
            fill_msg(rb + 3);
            send_msg(3'(m), rb - 9, 1'b0);
            send_msg(3'(m), rb - 8, 1'b1);
            send_msg(3'(m), rb - 1, 1'b0);
            send_msg(3'(m), rb, 1'b1);
            send_msg(3'(m), rb + 3, 1'b0);
            idle_inputs();
            wait_drain("boundary");
        end
    endtask

    task automatic test_back_to_back();
        fill_msg(200);
        send_msg(3'd1, 13, 1'b0);
        send_msg(3'd4, 136, 1'b0);
        send_msg(3'd6, 0, 1'b0);
        send_msg(3'd0, 200, 1'b0);
        send_msg(3'd7, 8, 1'b0);
        idle_inputs();
        wait_drain("back_to_back");
    endtask

    initial begin : main
        test_reset();
        test_empty_msg();
        test_full_then_pad();
        test_coincide();
        test_shake128();
        test_backpressure();
        test_reset_mid_fill();
        test_boundaries();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
